// File: rtl/jtpopeye_obj_dma.sv
// Vblank DMA: takes the Z80 bus and copies LEN bytes of object RAM into the sprite line buffer.
// Define JTPOPEYE_OBJ_DMA_DBUF_EN for a double-buffered destination (obj_addr gains a bank MSB).
module jtpopeye_obj_dma #(
   parameter logic [15:0] SRC_BASE = 16'h8C00,
   parameter logic [9:0]  LEN      = 10'd640,
   parameter int          AW       = 10,
`ifdef JTPOPEYE_OBJ_DMA_DBUF_EN
   localparam int         OAW      = AW + 1
`else
   localparam int         OAW      = AW
`endif
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           cen,
   input  logic           VB_n,
   input  logic           busak_n,
   output logic           busrq_n,
   output logic [15:0]    cpu_addr,
   output logic           cpu_rd_n,
   input  logic [7:0]     cpu_din,
   output logic [OAW-1:0] obj_addr,
   output logic [7:0]     obj_dout,
   output logic           obj_we,
   output logic           obj_bank,
   output logic           busy
);

   typedef enum logic [2:0] {IDLE, REQ, READ, WRITE, RELEASE} state_t;

   state_t         state, state_d;
   logic [9:0]     cnt, cnt_d;
   logic           vb_q;
   logic           start;
   logic           busrq_d, rd_d, we_d, busy_d, bank_d;
   logic [15:0]    addr_d;
   logic [OAW-1:0] oaddr_d;
   logic [7:0]     dout_d;

   // vb_q resets low so VB_n already low when reset lifts is not taken as an edge
   assign start = vb_q & ~VB_n;

   // NOTE: every signal gets its hold value first so no path through the case can infer a latch
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      busrq_d = busrq_n;
      rd_d    = cpu_rd_n;
      we_d    = obj_we;
      busy_d  = busy;
      addr_d  = cpu_addr;
      oaddr_d = obj_addr;
      dout_d  = obj_dout;
      bank_d  = obj_bank;
      case (state)
         IDLE: begin
            if (start) begin
               state_d = REQ;
               busrq_d = 1'b0;
               busy_d  = 1'b1;
            end
         end
         REQ: begin
            busrq_d = 1'b0;
            if (!busak_n) begin
               state_d = READ;
               cnt_d   = '0;
            end
         end
         READ: begin
            we_d = 1'b0;
            if (busak_n) begin
               rd_d = 1'b1;
            end else begin
               addr_d  = SRC_BASE + {6'd0, cnt};
               rd_d    = 1'b0;
               state_d = WRITE;
            end
         end
         WRITE: begin
            rd_d = 1'b1;
            if (busak_n) begin
               // bus lost mid-byte: data never arrived, so this byte is read again
               we_d    = 1'b0;
               state_d = READ;
            end else begin
               dout_d  = cpu_din;
`ifdef JTPOPEYE_OBJ_DMA_DBUF_EN
               oaddr_d = {~obj_bank, AW'(cnt)};
`else
               oaddr_d = AW'(cnt);
`endif
               we_d    = 1'b1;
               if (cnt == LEN - 10'd1) begin
                  state_d = RELEASE;
                  busrq_d = 1'b1;
               end else begin
                  cnt_d   = cnt + 10'd1;
                  state_d = READ;
               end
            end
         end
         RELEASE: begin
            busrq_d = 1'b1;
            we_d    = 1'b0;
            if (busak_n) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               bank_d  = ~obj_bank;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         vb_q     <= 1'b0;
         busrq_n  <= 1'b1;
         cpu_rd_n <= 1'b1;
         obj_we   <= 1'b0;
         busy     <= 1'b0;
         cpu_addr <= SRC_BASE;
         obj_addr <= '0;
         obj_dout <= '0;
      end else if (cen) begin
         state    <= state_d;
         cnt      <= cnt_d;
         vb_q     <= VB_n;
         busrq_n  <= busrq_d;
         cpu_rd_n <= rd_d;
         obj_we   <= we_d;
         busy     <= busy_d;
         cpu_addr <= addr_d;
         obj_addr <= oaddr_d;
         obj_dout <= dout_d;
      end
   end

`ifdef JTPOPEYE_OBJ_DMA_DBUF_EN
   always_ff @(posedge clk) begin
      if (rst)      obj_bank <= 1'b0;
      else if (cen) obj_bank <= bank_d;
   end
`else
   assign obj_bank = 1'b0;
`endif

endmodule

// File: tb/tb_jtpopeye_obj_dma.sv
// Self-checking bench for jtpopeye_obj_dma: directed vector table plus randomized-cen transfers.
// Honours JTPOPEYE_OBJ_DMA_DBUF_EN to check the bank bit and bank toggling.
module tb_jtpopeye_obj_dma;

   localparam logic [15:0] SRC_BASE = 16'h8C00;
   localparam int          LEN      = 4;
   localparam int          AW       = 10;
`ifdef JTPOPEYE_OBJ_DMA_DBUF_EN
   localparam int          OAW      = AW + 1;
`else
   localparam int          OAW      = AW;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           cen = 1'b1;
   logic           VB_n = 1'b1;
   logic           busak_n;
   logic           busrq_n;
   logic [15:0]    cpu_addr;
   logic           cpu_rd_n;
   logic [7:0]     cpu_din;
   logic [OAW-1:0] obj_addr;
   logic [7:0]     obj_dout;
   logic           obj_we;
   logic           obj_bank;
   logic           busy;

   logic [7:0]     salt = 8'h00;
   logic           steal = 1'b0;
   logic           cen_rand = 1'b0;
   logic           ack_d1 = 1'b1, ack_d2 = 1'b1;
   logic           exp_bank = 1'b0;
   int             n_checks = 0;
   int             n_fail = 0;

   jtpopeye_obj_dma #(.SRC_BASE(SRC_BASE), .LEN(10'(LEN)), .AW(AW)) dut (
      .clk(clk), .rst(rst), .cen(cen), .VB_n(VB_n), .busak_n(busak_n),
      .busrq_n(busrq_n), .cpu_addr(cpu_addr), .cpu_rd_n(cpu_rd_n), .cpu_din(cpu_din),
      .obj_addr(obj_addr), .obj_dout(obj_dout), .obj_we(obj_we),
      .obj_bank(obj_bank), .busy(busy)
   );

   always #5 clk = ~clk;

   // Z80 grants the bus two clocks after the request; steal forces it away
   always @(posedge clk) begin
      ack_d1 <= busrq_n;
      ack_d2 <= ack_d1;
   end
   assign busak_n = ack_d2 | steal;
   assign cpu_din = cpu_addr[7:0] ^ salt;

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (cen_rand) cen = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Make sure at least one cen edge samples VB_n high before the falling edge
   task automatic arm_vb();
      int k;
      VB_n = 1'b1;
      repeat (4) @(negedge clk);
      k = 0;
      while (!cen && k < 100) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
   endtask

   task automatic run_xfer(input logic [7:0] s, input int steal_byte, input bit extra_edge,
                           input int exp_reads, input bit strict);
      int writes, reads, cyc, gap_bad, early, steal_left, late_busy;
      bit stolen, seen_busy, done;
      logic [OAW-1:0] ea;
      logic [15:0] sa;
      writes = 0; reads = 0; cyc = 0; gap_bad = 0; early = 0; steal_left = 0;
      stolen = 0; seen_busy = 0; done = 0;
      salt = s;
      arm_vb();
      check("bank before xfer", obj_bank, exp_bank);
      VB_n = 1'b0;
      if (strict) begin
         @(negedge clk);
         check("busrq_n one cen after edge", busrq_n, 1'b0);
         check("busy one cen after edge", busy, 1'b1);
      end
      while (!done && cyc < 400) begin
         @(negedge clk);
         if (cen && obj_we) begin
            if (writes < LEN) begin
               ea = OAW'(writes);
`ifdef JTPOPEYE_OBJ_DMA_DBUF_EN
               ea[OAW-1] = ~exp_bank;
`endif
               sa = SRC_BASE + 16'(writes);
               check($sformatf("write %0d addr", writes), obj_addr, ea);
               check($sformatf("write %0d data", writes), obj_dout, sa[7:0] ^ s);
            end
            writes++;
         end
         if (cen && !cpu_rd_n) reads++;
         if (busy && busrq_n && (writes + int'(obj_we && !cen)) < LEN) early++;
         if (steal_left > 0) begin
            if (!cpu_rd_n || obj_we) gap_bad++;
            steal_left--;
            if (steal_left == 0) steal = 1'b0;
         end else if (!stolen && steal_byte >= 0 && !cpu_rd_n &&
                      cpu_addr == SRC_BASE + 16'(steal_byte)) begin
            steal = 1'b1;
            stolen = 1;
            steal_left = 5;
         end
         if (extra_edge && cyc == 6)  VB_n = 1'b1;
         if (extra_edge && cyc == 10) VB_n = 1'b0;
         if (busy) seen_busy = 1;
         if (seen_busy && !busy) done = 1;
         cyc++;
      end
      steal = 1'b0;
      check("transfer completes", done, 1'b1);
      check("write count", writes, LEN);
      if (exp_reads >= 0) check("read count", reads, exp_reads);
      else                check("read count >= LEN", reads >= LEN, 1'b1);
      if (strict && steal_byte >= 0) check("no strobes while bus lost", gap_bad, 0);
      check("busrq_n held until last write", early, 0);
      check("busrq_n released", busrq_n, 1'b1);
`ifdef JTPOPEYE_OBJ_DMA_DBUF_EN
      exp_bank = ~exp_bank;
`endif
      check("bank after xfer", obj_bank, exp_bank);
      if (extra_edge) begin
         late_busy = 0;
         repeat (20) begin
            @(negedge clk);
            if (busy || obj_we) late_busy++;
         end
         check("second edge ignored", late_busy, 0);
      end
   endtask

   typedef struct {
      logic [7:0] salt;
      int         steal_byte;
      bit         extra_edge;
      int         exp_reads;
   } vec_t;

   initial begin
      vec_t vecs[4];
      int   k, bad, writes;

      vecs[0] = '{8'h00, -1, 1'b0, 4};
      vecs[1] = '{8'h5A,  2, 1'b0, 5};
      vecs[2] = '{8'hFF,  0, 1'b1, 5};
      vecs[3] = '{8'h33,  3, 1'b1, 5};

      repeat (3) @(negedge clk);
      check("reset busrq_n", busrq_n, 1'b1);
      check("reset cpu_rd_n", cpu_rd_n, 1'b1);
      check("reset obj_we", obj_we, 1'b0);
      check("reset busy", busy, 1'b0);
      check("reset obj_bank", obj_bank, 1'b0);
      check("reset cpu_addr", cpu_addr, SRC_BASE);
      check("reset obj_addr", obj_addr, 0);
      check("reset obj_dout", obj_dout, 0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++)
         run_xfer(vecs[i].salt, vecs[i].steal_byte, vecs[i].extra_edge, vecs[i].exp_reads, 1'b1);

      // Bus never granted: hold in REQ with no strobes
      steal = 1'b1;
      salt = 8'h00;
      arm_vb();
      VB_n = 1'b0;
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (busrq_n || !cpu_rd_n || obj_we || !busy) bad++;
      end
      check("no ack: parked in REQ", bad, 0);
      steal = 1'b0;
      writes = 0;
      k = 0;
      while (busy && k < 200) begin
         @(negedge clk);
         if (cen && obj_we) writes++;
         k++;
      end
      check("no ack: completes after grant", busy, 1'b0);
      check("no ack: write count", writes, LEN);
`ifdef JTPOPEYE_OBJ_DMA_DBUF_EN
      exp_bank = ~exp_bank;
`endif
      check("no ack: bank", obj_bank, exp_bank);

      // Reset in the middle of byte 1
      arm_vb();
      VB_n = 1'b0;
      k = 0;
      while (!(!cpu_rd_n && cpu_addr == SRC_BASE + 16'd1) && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("reached byte 1", k < 100, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("mid reset busrq_n", busrq_n, 1'b1);
      check("mid reset obj_we", obj_we, 1'b0);
      check("mid reset cpu_rd_n", cpu_rd_n, 1'b1);
      check("mid reset busy", busy, 1'b0);
      check("mid reset obj_addr", obj_addr, 0);
      rst = 1'b0;
      exp_bank = 1'b0;
      run_xfer(8'h11, -1, 1'b0, 4, 1'b1);

      // Randomized clock enable, data, bus steals and spurious edges
      cen_rand = 1'b1;
      for (int i = 0; i < 8; i++)
         run_xfer(8'($urandom), int'($urandom_range(0, 4)) - 1, 1'($urandom_range(0, 1)), -1, 1'b0);
      cen_rand = 1'b0;
      @(posedge clk);
      #2 cen = 1'b1;
      run_xfer(8'hC3, 1, 1'b0, 5, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
